pipeline_fetch_queued: RTL and testbench

//   Parametrised fetch stage with a decoupled prefetch queue. Issues PCs to instruction memory over a

---
 rtl/pipeline_fetch_queued_pkg.sv | 23 ++
 rtl/pipeline_fetch_queued_queue.sv | 72 +++++++
 rtl/pipeline_fetch_queued.sv | 202 ++++++++++++++++++++
 tb/tb_pipeline_fetch_queued.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_fetch_queued_pkg.sv
// Shared definitions for the queued fetch stage: exception codes and queue-entry layout.
// An entry is packed as {pc, data, exc} with the exception code in the low bits.
package pipeline_fetch_queued_pkg;

  typedef enum logic [2:0] {
    FeNone  = 3'd0,
    FeBus   = 3'd1,
    FeAlign = 3'd2
  } fetch_exc_e;

  localparam int unsigned ExcW    = 3;
  localparam int unsigned ExcLsb  = 0;
  localparam int unsigned DataLsb = ExcLsb + ExcW;

  function automatic int unsigned pc_lsb(input int unsigned dw);
    return DataLsb + dw;
  endfunction

  function automatic int unsigned entry_w(input int unsigned aw, input int unsigned dw);
    return aw + dw + ExcW;
  endfunction

endpackage

// File: rtl/pipeline_fetch_queued_queue.sv
// Synchronous FIFO with push/pop/flush and an occupancy count; flush wins over push and pop.
// Used both as the prefetch queue and as the in-flight PC tag FIFO.
module pipeline_fetch_queued_queue #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic            pop_i,
  output logic [Width-1:0] rdata_o,
  output logic            empty_o,
  output logic            full_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pipeline_fetch_queued.sv
// Fetch stage with a credit-limited prefetch queue, in-order variable-latency imem reads,
// and late/early branch redirects that flush the queue and discard in-flight responses.
module pipeline_fetch_queued
  import pipeline_fetch_queued_pkg::*;
#(
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STALL_W         = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      initial_pc,
  input  logic               br_late_enable,
  input  logic [AW-1:0]      br_target,
  input  logic               early_br_valid,
  input  logic [AW-1:0]      early_br_target,
  input  logic [STALL_W-1:0] stall_request,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [AW-1:0]      imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [DW-1:0]      imem_rsp_data,
  input  logic               imem_rsp_fault,
  output logic               out_valid,
  output logic [AW-1:0]      pc_out,
  output logic [DW-1:0]      inst_out,
  output logic [2:0]         fetch_exception,
  output logic               br_late_done_d1
);

  localparam int unsigned EntryW = entry_w(AW, DW);
  localparam int unsigned PcLsb  = pc_lsb(DW);
  localparam int unsigned QCntW  = $clog2(DEPTH + 1);
  localparam int unsigned TCntW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned OutW   = $clog2(MAX_OUTSTANDING + 1);

  logic [AW-1:0]      fetch_pc_q, fetch_pc_d;
  logic [OutW-1:0]    outstanding_q, outstanding_d;
  logic [OutW-1:0]    drop_cnt_q, drop_cnt_d;
  logic               fault_hold_q, fault_hold_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               first_cycle_q;
  logic               late_pend_q, late_pend_d;
  logic               late_done_q, late_done_d;

  logic               redirect;
  logic [AW-1:0]      redirect_pc;
  logic               misaligned, credit_ok, can_fetch, req_fire;
  logic               drop_rsp, keep_rsp, align_push;
  logic               stall_active, pop;

  logic [EntryW-1:0]  q_wdata, q_rdata;
  logic               q_push, q_empty, q_full;
  logic [QCntW-1:0]   q_count;
  logic [AW-1:0]      push_pc;
  logic [DW-1:0]      push_data;
  fetch_exc_e         push_exc;

  logic [AW-1:0]      tag_pc;
  logic               tag_empty, tag_full;
  logic [TCntW-1:0]   tag_count;
  logic               unused_tag;

  // Late branch takes priority; an early branch in the same cycle is ignored.
  assign redirect    = br_late_enable || early_br_valid;
  assign redirect_pc = br_late_enable ? br_target : early_br_target;

  assign misaligned = (fetch_pc_q[1:0] != 2'b00);
  // Every in-flight read already owns a queue slot, so the queue cannot overflow.
  assign credit_ok  = (32'(q_count) + 32'(outstanding_q)) < 32'(DEPTH);
  assign can_fetch  = rst && !fault_hold_q && !redirect;

  assign imem_req_valid = can_fetch && !misaligned && credit_ok
                       && (outstanding_q < OutW'(MAX_OUTSTANDING));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign drop_rsp = imem_rsp_valid && (redirect || (drop_cnt_q != '0));
  assign keep_rsp = imem_rsp_valid && !drop_rsp;

  // Wait for all reads to drain so the alignment fault lands behind them in order.
  assign align_push = can_fetch && misaligned && (outstanding_q == '0) && credit_ok;

  assign q_push = keep_rsp || align_push;

  always_comb begin
    push_pc   = fetch_pc_q;
    push_data = '0;
    push_exc  = FeAlign;
    if (keep_rsp) begin
      push_pc   = tag_pc;
      push_data = imem_rsp_data;
      push_exc  = imem_rsp_fault ? FeBus : FeNone;
    end
  end

  assign q_wdata = {push_pc, push_data, push_exc};

  assign stall_active = !first_cycle_q && ((stall_request != '0) || (stall_cnt_q != '0));
  assign out_valid    = !q_empty && !stall_active && !first_cycle_q && !redirect;
  assign pop          = out_valid;

  assign pc_out          = out_valid ? q_rdata[PcLsb +: AW] : '0;
  assign inst_out        = out_valid ? q_rdata[DataLsb +: DW] : '0;
  assign fetch_exception = out_valid ? q_rdata[ExcLsb +: ExcW] : '0;
  assign br_late_done_d1 = late_done_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + OutW'(req_fire) - OutW'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    fault_hold_d  = fault_hold_q;
    stall_cnt_d   = stall_cnt_q;
    late_pend_d   = late_pend_q;
    late_done_d   = out_valid && late_pend_q;

    if (redirect) begin
      fetch_pc_d   = redirect_pc;
      // Everything still in flight after this edge belongs to the old stream.
      drop_cnt_d   = outstanding_d;
      fault_hold_d = 1'b0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + AW'(4);
      if (drop_rsp) drop_cnt_d = drop_cnt_q - OutW'(1);
      if ((keep_rsp && imem_rsp_fault) || align_push) fault_hold_d = 1'b1;
    end

    if (first_cycle_q) begin
      stall_cnt_d = '0;
    end else if (stall_request != '0) begin
      stall_cnt_d = stall_request - STALL_W'(1);
    end else if (stall_cnt_q != '0) begin
      stall_cnt_d = stall_cnt_q - STALL_W'(1);
    end

    if (br_late_enable) begin
      late_pend_d = 1'b1;
    end else if (out_valid) begin
      late_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= initial_pc;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fault_hold_q  <= 1'b0;
      stall_cnt_q   <= '0;
      first_cycle_q <= 1'b1;
      late_pend_q   <= 1'b0;
      late_done_q   <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fault_hold_q  <= fault_hold_d;
      stall_cnt_q   <= stall_cnt_d;
      first_cycle_q <= 1'b0;
      late_pend_q   <= late_pend_d;
      late_done_q   <= late_done_d;
    end
  end

  pipeline_fetch_queued_queue #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_prefetch_q (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (redirect),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (pop),
    .rdata_o (q_rdata),
    .empty_o (q_empty),
    .full_o  (q_full),
    .count_o (q_count)
  );

  // Tags of dropped reads are flushed with the redirect, so only kept responses pop.
  pipeline_fetch_queued_queue #(
    .Width (AW),
    .Depth (MAX_OUTSTANDING)
  ) u_tag_q (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (redirect),
    .push_i  (req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (keep_rsp),
    .rdata_o (tag_pc),
    .empty_o (tag_empty),
    .full_o  (tag_full),
    .count_o (tag_count)
  );

  assign unused_tag = ^{tag_empty, tag_full, tag_count, q_full};

endmodule

// File: tb/tb_pipeline_fetch_queued.sv
// Directed bench for pipeline_fetch_queued: cycle-exact vector table plus fault/misalign/reset sequences.
// Includes an in-order imem model with fixed 2-cycle response latency.
module tb_pipeline_fetch_queued;

  localparam int Lat = 2;
  localparam int MaxOut = 2;
  localparam logic [31:0] DataKey = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] initial_pc;
  logic        br_late_enable;
  logic [31:0] br_target;
  logic        early_br_valid;
  logic [31:0] early_br_target;
  logic [1:0]  stall_request;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_fault;
  logic        out_valid;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic [2:0]  fetch_exception;
  logic        br_late_done_d1;

  pipeline_fetch_queued dut (
    .clk             (clk),
    .rst             (rst),
    .initial_pc      (initial_pc),
    .br_late_enable  (br_late_enable),
    .br_target       (br_target),
    .early_br_valid  (early_br_valid),
    .early_br_target (early_br_target),
    .stall_request   (stall_request),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .imem_rsp_fault  (imem_rsp_fault),
    .out_valid       (out_valid),
    .pc_out          (pc_out),
    .inst_out        (inst_out),
    .fetch_exception (fetch_exception),
    .br_late_done_d1 (br_late_done_d1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [1:0]  stall;
    logic        late;
    logic        early;
    logic [31:0] tgt;
    logic [31:0] etgt;
    logic        ov;
    logic [31:0] pc;
    logic        rv;
    logic [31:0] ra;
    logic        done;
  } vec_t;

  pend_t       pend[$];
  vec_t        vecs[$];
  int          cyc;
  int          n_tests = 0;
  int          n_fail = 0;
  int          max_inflight = 0;
  logic        saw_800 = 1'b0;
  logic        fault_en = 1'b0;
  logic [31:0] fault_addr = 32'h0;

  logic        s_rv, s_ov, s_done;
  logic [31:0] s_ra, s_pc, s_inst;
  logic [2:0]  s_exc;

  function automatic vec_t mk(input logic [1:0] stall, input logic late, input logic early,
                              input logic [31:0] tgt, input logic [31:0] etgt, input logic ov,
                              input logic [31:0] pc, input logic rv, input logic [31:0] ra,
                              input logic done);
    vec_t v;
    v.stall = stall; v.late = late; v.early = early; v.tgt = tgt; v.etgt = etgt;
    v.ov = ov; v.pc = pc; v.rv = rv; v.ra = ra; v.done = done;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: present memory response, sample DUT, model the handshake, advance.
  task automatic step();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].addr ^ DataKey;
      imem_rsp_fault = fault_en && (pend[0].addr == fault_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_rsp_fault = 1'b0;
    end
    #1;
    s_rv = imem_req_valid; s_ra = imem_req_addr; s_ov = out_valid; s_pc = pc_out;
    s_inst = inst_out; s_exc = fetch_exception; s_done = br_late_done_d1;
    if (imem_req_valid && imem_req_ready) begin
      pend.push_back('{addr: imem_req_addr, due: cyc + Lat});
      if (imem_req_addr == 32'h800) saw_800 = 1'b1;
    end
    if (imem_rsp_valid) void'(pend.pop_front());
    if (pend.size() > max_inflight) max_inflight = pend.size();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_ctl();
    stall_request = 2'd0; br_late_enable = 1'b0; early_br_valid = 1'b0;
    br_target = 32'h0; early_br_target = 32'h0;
  endtask

  initial begin
    int n_out;
    int n_req;
    logic [31:0] o_pc [8];
    logic [2:0]  o_exc [8];
    logic [31:0] o_inst [8];
    logic        got;

    rst = 1'b0; initial_pc = 32'h100; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_fault = 1'b0;
    clear_ctl();

    // Cycle-exact vectors from reset release (ready=1, latency 2).
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h100, 0)); // c0
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h104, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      0, 0,       0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h100, 1, 32'h108, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h104, 1, 32'h10C, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      0, 0,       0)); // c5
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h108, 1, 32'h110, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h10C, 1, 32'h114, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      0, 0,       0));
    vecs.push_back(mk(3, 0, 0, 0, 0,           0, 0,      1, 32'h118, 0)); // c9 stall
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h11C, 0)); // c10
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      0, 0,       0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h110, 0, 0,       0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h114, 1, 32'h120, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h118, 1, 32'h124, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h11C, 0, 0,       0)); // c15
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h120, 1, 32'h128, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h124, 1, 32'h12C, 0));
    vecs.push_back(mk(0, 1, 0, 32'h400, 0,     0, 0,      0, 0,       0)); // c18 late
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h400, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h404, 0)); // c20
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      0, 0,       0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h400, 1, 32'h408, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h404, 1, 32'h40C, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      0, 0,       0));
    vecs.push_back(mk(0, 1, 1, 32'h400, 32'h800, 0, 0,    0, 0,       0)); // c25 late+early
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h400, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      1, 32'h404, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      0, 0,       0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h400, 1, 32'h408, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,           1, 32'h404, 1, 32'h40C, 1)); // c30
    vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0,      0, 0,       0));

    repeat (2) @(negedge clk);
    #1;
    check("reset req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset inst_out", inst_out, 32'h0);
    check("reset exception", {29'h0, fetch_exception}, 32'h0);
    check("reset br_late_done", {31'h0, br_late_done_d1}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      stall_request = vecs[i].stall; br_late_enable = vecs[i].late; br_target = vecs[i].tgt;
      early_br_valid = vecs[i].early; early_br_target = vecs[i].etgt;
      step();
      check($sformatf("c%0d out_valid", i), {31'h0, s_ov}, {31'h0, vecs[i].ov});
      check($sformatf("c%0d req_valid", i), {31'h0, s_rv}, {31'h0, vecs[i].rv});
      check($sformatf("c%0d late_done", i), {31'h0, s_done}, {31'h0, vecs[i].done});
      if (vecs[i].ov) begin
        check($sformatf("c%0d pc_out", i), s_pc, vecs[i].pc);
        check($sformatf("c%0d inst_out", i), s_inst, vecs[i].pc ^ DataKey);
        check($sformatf("c%0d exception", i), {29'h0, s_exc}, 32'h0);
      end
      if (vecs[i].rv) check($sformatf("c%0d req_addr", i), s_ra, vecs[i].ra);
    end
    clear_ctl();

    // Bus fault on 0x108 after an early redirect to 0x100.
    fault_en = 1'b1; fault_addr = 32'h108;
    early_br_valid = 1'b1; early_br_target = 32'h100;
    step();
    clear_ctl();
    n_out = 0; n_req = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (s_ov && n_out < 8) begin
        o_pc[n_out] = s_pc; o_exc[n_out] = s_exc; o_inst[n_out] = s_inst; n_out++;
      end
      if (i >= 8 && s_rv) n_req++;
    end
    check("fault out count", n_out, 4);
    check("fault pc0", o_pc[0], 32'h100);
    check("fault pc1", o_pc[1], 32'h104);
    check("fault pc2", o_pc[2], 32'h108);
    check("fault exc1", {29'h0, o_exc[1]}, 32'h0);
    check("fault exc2", {29'h0, o_exc[2]}, 32'h1);
    check("fault inst1", o_inst[1], 32'h104 ^ DataKey);
    check("fault no req", n_req, 0);
    fault_en = 1'b0;

    // Misaligned early target: one alignment-fault entry, no request.
    early_br_valid = 1'b1; early_br_target = 32'h202;
    step();
    clear_ctl();
    n_out = 0; n_req = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_ov && n_out < 8) begin
        o_pc[n_out] = s_pc; o_exc[n_out] = s_exc; o_inst[n_out] = s_inst; n_out++;
      end
      if (s_rv) n_req++;
    end
    check("align out count", n_out, 1);
    check("align pc", o_pc[0], 32'h202);
    check("align exc", {29'h0, o_exc[0]}, 32'h2);
    check("align inst", o_inst[0], 32'h0);
    check("align no req", n_req, 0);

    // Reset in the middle of a burst.
    br_late_enable = 1'b1; br_target = 32'h100;
    step();
    clear_ctl();
    repeat (4) step();
    rst = 1'b0;
    pend.delete();
    #1;
    check("midrst req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("midrst out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst inst_out", inst_out, 32'h0);
    check("midrst exception", {29'h0, fetch_exception}, 32'h0);
    check("midrst late_done", {31'h0, br_late_done_d1}, 32'h0);
    initial_pc = 32'h300; imem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp%0d req_valid", i), {31'h0, s_rv}, 32'h1);
      check($sformatf("bp%0d req_addr", i), s_ra, 32'h300);
      check($sformatf("bp%0d out_valid", i), {31'h0, s_ov}, 32'h0);
    end
    imem_req_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (s_ov) begin
        got = 1'b1;
        check("post-reset pc", s_pc, 32'h300);
        check("post-reset inst", s_inst, 32'h300 ^ DataKey);
      end
    end
    check("post-reset output seen", {31'h0, got}, 32'h1);

    check("0x800 never requested", {31'h0, saw_800}, 32'h0);
    check("max in flight", (max_inflight <= MaxOut) ? 32'h1 : 32'h0, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
